// File: rtl/sport1_tx_ctl_pkg.sv
// -----------------------------------------------------------------------------
// sport1_tx_ctl_pkg
// Shared definitions for the SPORT1 serial engines. The transmit and receive
// controllers use the same one-hot state encoding, so both live here.
// No ports; imported by sport1_tx_ctl and sport1_tx_shreg.
// -----------------------------------------------------------------------------
package sport1_tx_ctl_pkg;

  typedef enum logic [2:0] {
    TX_idle   = 3'b001,
    TX_shift  = 3'b010,
    TX_wstart = 3'b100
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_idle   = 3'b001,
    RX_shift  = 3'b010,
    RX_wstart = 3'b100
  } rx_state_t;

  // Widest word the shifter can serialise (SLEN saturates here).
  localparam int SHIFT_MAX_BIT = 15;

endpackage

// File: rtl/sport1_tx_shreg.sv
// -----------------------------------------------------------------------------
// sport1_tx_shreg
// Transmit shifter for SPORT1: captures the TX holding register on a load,
// counts the bits of the word down and drives the registered serial bit.
// Ports:
//   clk, rst_n   core clock, asynchronous active-low reset
//   clr          synchronous clear of counter and DT (port disabled)
//   ld           load TXSHT from tx and present its MSB (bit SLEN)
//   shift_en     present the next lower bit and decrement the counter
//   dt_zero      drive DT low (end of word / inter-word gap)
//   slen         word length minus 1, saturated to the shifter width
//   tx           transmit holding register contents
//   dt           serial data out
//   bcnt_eq0     last bit of the current word is on DT
// -----------------------------------------------------------------------------
module sport1_tx_shreg
  import sport1_tx_ctl_pkg::*;
#(
  parameter int DW = 16,
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          ld,
  input  logic          shift_en,
  input  logic          dt_zero,
  input  logic [CW-1:0] slen,
  input  logic [DW-1:0] tx,
  output logic          dt,
  output logic          bcnt_eq0
);

  logic [DW-1:0] txsht;
  logic [CW-1:0] bcnt;
  logic [CW-1:0] slen_c;
  logic [CW-1:0] bcnt_m1;

  function automatic logic [CW-1:0] clamp_slen(input logic [CW-1:0] v);
    return (v > CW'(SHIFT_MAX_BIT)) ? CW'(SHIFT_MAX_BIT) : v;
  endfunction

  // Mask-and-reduce select keeps the index free of width truncation.
  function automatic logic bit_at(input logic [DW-1:0] v, input logic [CW-1:0] i);
    return |(v & (DW'(1) << i));
  endfunction

  assign slen_c   = clamp_slen(slen);
  assign bcnt_m1  = bcnt - CW'(1);
  assign bcnt_eq0 = (bcnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txsht <= '0;
      bcnt  <= '0;
      dt    <= 1'b0;
    end else if (clr) begin
      // TXSHT is left alone; only the bit engine is cleared.
      bcnt <= '0;
      dt   <= 1'b0;
    end else if (ld) begin
      txsht <= tx;
      bcnt  <= slen_c;
      dt    <= bit_at(tx, slen_c);
    end else if (shift_en) begin
      bcnt <= bcnt_m1;
      dt   <= bit_at(txsht, bcnt_m1);
    end else if (dt_zero) begin
      dt <= 1'b0;
    end
  end

endmodule

// File: rtl/sport1_tx_ctl.sv
// -----------------------------------------------------------------------------
// sport1_tx_ctl
// SPORT1 transmit controller. Holds the TX register (core or autobuffer
// writes), sequences frames of MWORD[7:0]+1 words of SLEN+1 bits each with a
// one-bit gap between words, and raises the autobuffer request and the
// transmit interrupt. All serial activity is qualified by SCLK_en.
// Ports:
//   DSPCLK, RST_      core clock, asynchronous active-low reset
//   SP_EN             port enable (low = synchronous clear of the engine)
//   SCLK_en           one-cycle serial bit tick
//   TFSsm             frame sync start, honoured on a tick while idle
//   SLEN, MWORD       word length-1, words per frame-1 (MWORD[7:0])
//   DMD               core data bus
//   MTTX_E/EX_en/GO_Cx TX register write qualifiers
//   TBUF/TSack/Twrap  autobuffer mode, acknowledge, wrap
//   TX                transmit holding register
//   DT, DT_OE         serial data and its drive enable
//   TSreq             autobuffer request
//   ISX               transmit interrupt
//   TUF               sticky underflow (stale word resent)
// -----------------------------------------------------------------------------
module sport1_tx_ctl
  import sport1_tx_ctl_pkg::*;
#(
  parameter int DW = 16,
  parameter int CW = 5
) (
  input  logic          DSPCLK,
  input  logic          RST_,
  input  logic          SP_EN,
  input  logic          SCLK_en,
  input  logic          TFSsm,
  input  logic [CW-1:0] SLEN,
  input  logic [15:0]   MWORD,
  input  logic [DW-1:0] DMD,
  input  logic          MTTX_E,
  input  logic          EX_en,
  input  logic          GO_Cx,
  input  logic          TBUF,
  input  logic          TSack,
  input  logic          Twrap,
  output logic [DW-1:0] TX,
  output logic          DT,
  output logic          DT_OE,
  output logic          TSreq,
  output logic          ISX,
  output logic          TUF
);

  tx_state_t  state;
  tx_state_t  state_nx;
  logic [7:0] wcnt;
  logic       tx_full;
  logic       isxa;

  logic wr;
  logic tick;
  logic ld_first;
  logic ld;
  logic shift_en;
  logic word_end;
  logic frame_end;
  logic bcnt_eq0;
  logic unused_mword;

  // Only the low byte of MWORD configures the transmitter.
  assign unused_mword = ^MWORD[15:8];

  assign wr        = MTTX_E & EX_en & GO_Cx;
  assign tick      = SCLK_en & SP_EN;
  assign ld_first  = tick & (state == TX_idle) & TFSsm;
  assign ld        = ld_first | (tick & (state == TX_wstart));
  assign shift_en  = tick & (state == TX_shift) & !bcnt_eq0;
  assign word_end  = tick & (state == TX_shift) & bcnt_eq0;
  assign frame_end = word_end & (wcnt == 8'd0);

  sport1_tx_shreg #(
    .DW (DW),
    .CW (CW)
  ) u_shreg (
    .clk      (DSPCLK),
    .rst_n    (RST_),
    .clr      (!SP_EN),
    .ld       (ld),
    .shift_en (shift_en),
    .dt_zero  (word_end),
    .slen     (SLEN),
    .tx       (TX),
    .dt       (DT),
    .bcnt_eq0 (bcnt_eq0)
  );

  always_ff @(posedge DSPCLK or negedge RST_) begin
    if (!RST_) begin
      state <= TX_idle;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (!SP_EN) begin
      state_nx = TX_idle;
    end else if (SCLK_en) begin
      case (state)
        TX_idle:   if (TFSsm) state_nx = TX_shift;
        TX_shift:  if (bcnt_eq0) state_nx = (wcnt == 8'd0) ? TX_idle : TX_wstart;
        TX_wstart: state_nx = TX_shift;
        default:   state_nx = TX_idle;
      endcase
    end
  end

  // Words remaining in the frame after the current one.
  always_ff @(posedge DSPCLK or negedge RST_) begin
    if (!RST_) begin
      wcnt <= 8'd0;
    end else if (!SP_EN) begin
      wcnt <= 8'd0;
    end else if (ld_first) begin
      wcnt <= MWORD[7:0];
    end else if (word_end && (wcnt != 8'd0)) begin
      wcnt <= wcnt - 8'd1;
    end
  end

  // DT_OE stays high across inter-word gaps, drops only at frame end.
  always_ff @(posedge DSPCLK or negedge RST_) begin
    if (!RST_) begin
      DT_OE <= 1'b0;
    end else if (!SP_EN) begin
      DT_OE <= 1'b0;
    end else if (ld) begin
      DT_OE <= 1'b1;
    end else if (frame_end) begin
      DT_OE <= 1'b0;
    end
  end

  // A write coinciding with a load wins: the shifter takes the old word,
  // the new one stays pending and no underflow is flagged.
  always_ff @(posedge DSPCLK or negedge RST_) begin
    if (!RST_) begin
      TX      <= '0;
      tx_full <= 1'b0;
      TUF     <= 1'b0;
    end else begin
      if (wr) begin
        TX <= DMD;
      end
      if (wr) begin
        tx_full <= 1'b1;
        TUF     <= 1'b0;
      end else if (ld) begin
        tx_full <= 1'b0;
        if (!tx_full) TUF <= 1'b1;
      end
    end
  end

  // Acknowledge beats a coincident new request.
  always_ff @(posedge DSPCLK or negedge RST_) begin
    if (!RST_) begin
      TSreq <= 1'b0;
      isxa  <= 1'b0;
    end else begin
      if (TSack) begin
        TSreq <= 1'b0;
      end else if (ld && SP_EN && TBUF) begin
        TSreq <= 1'b1;
      end
      isxa <= SP_EN & ld;
    end
  end

  assign ISX = TBUF ? Twrap : isxa;

endmodule

// File: tb/tb_sport1_tx_ctl.sv
module tb_sport1_tx_ctl;

  logic        DSPCLK = 1'b0;
  logic        RST_;
  logic        SP_EN;
  logic        SCLK_en;
  logic        TFSsm;
  logic [4:0]  SLEN;
  logic [15:0] MWORD;
  logic [15:0] DMD;
  logic        MTTX_E;
  logic        EX_en;
  logic        GO_Cx;
  logic        TBUF;
  logic        TSack;
  logic        Twrap;
  logic [15:0] TX;
  logic        DT;
  logic        DT_OE;
  logic        TSreq;
  logic        ISX;
  logic        TUF;

  int checks   = 0;
  int failures = 0;

  // Reference model of the TX register side.
  logic [15:0] tx_m;
  logic        full_m;
  logic        tuf_m;
  logic [15:0] wdat [0:255];
  logic [15:0] w0dat;

  always #5 DSPCLK = ~DSPCLK;

  sport1_tx_ctl dut (
    .DSPCLK  (DSPCLK),
    .RST_    (RST_),
    .SP_EN   (SP_EN),
    .SCLK_en (SCLK_en),
    .TFSsm   (TFSsm),
    .SLEN    (SLEN),
    .MWORD   (MWORD),
    .DMD     (DMD),
    .MTTX_E  (MTTX_E),
    .EX_en   (EX_en),
    .GO_Cx   (GO_Cx),
    .TBUF    (TBUF),
    .TSack   (TSack),
    .Twrap   (Twrap),
    .TX      (TX),
    .DT      (DT),
    .DT_OE   (DT_OE),
    .TSreq   (TSreq),
    .ISX     (ISX),
    .TUF     (TUF)
  );

  task automatic cyc();
    @(posedge DSPCLK);
    #1;
  endtask

  task automatic do_write(input logic [15:0] d);
    DMD = d; MTTX_E = 1'b1; EX_en = 1'b1; GO_Cx = 1'b1;
    cyc();
    MTTX_E = 1'b0; EX_en = 1'b0; GO_Cx = 1'b0;
    tx_m = d; full_m = 1'b1; tuf_m = 1'b0;
  endtask

  // Runs one frame from the TFSsm tick to the tick that drops DT_OE.
  // Expected serial stream: each loaded word MSB-first over s+1 ticks,
  // a zero gap tick between words, then DT/DT_OE low.
  task automatic frame(input int slen_in, input int m, input int nwr, input bit wr0);
    int s, per, last, pos;
    logic [15:0] loaded [0:255];
    bit is_ld, did_wr;
    logic exp_dt, exp_oe;
    s    = (slen_in > 15) ? 15 : slen_in;
    per  = s + 2;
    last = (m + 1) * per - 1;
    SLEN  = 5'(slen_in);
    MWORD = {8'($urandom), 8'(m)};
    for (int t = 0; t <= last; t++) begin
      if (t > 0) begin
        repeat ($urandom_range(0, 2)) begin
          cyc();
          checks++;
          if (ISX !== 1'b0) begin
            failures++;
            $display("FAIL isx_idle tick=%0d got %b want 0", t, ISX);
          end
        end
      end
      SCLK_en = 1'b1;
      TFSsm   = (t == 0) ? 1'b1 : 1'($urandom);
      did_wr  = (t == 0) && wr0;
      if (did_wr) begin
        DMD = w0dat; MTTX_E = 1'b1; EX_en = 1'b1; GO_Cx = 1'b1;
      end
      cyc();
      SCLK_en = 1'b0; TFSsm = 1'b0; MTTX_E = 1'b0; EX_en = 1'b0; GO_Cx = 1'b0;
      pos   = t % per;
      is_ld = (pos == 0) && (t < last);
      if (is_ld) begin
        loaded[t / per] = tx_m;
        if (!full_m) tuf_m = 1'b1;
        full_m = 1'b0;
      end
      if (did_wr) begin
        tx_m = w0dat; full_m = 1'b1; tuf_m = 1'b0;
      end
      if (t == last) begin
        exp_dt = 1'b0; exp_oe = 1'b0;
      end else if (pos <= s) begin
        exp_dt = loaded[t / per][s - pos]; exp_oe = 1'b1;
      end else begin
        exp_dt = 1'b0; exp_oe = 1'b1;
      end
      checks++;
      if ({DT, DT_OE} !== {exp_dt, exp_oe}) begin
        failures++;
        $display("FAIL frame_dt slen=%0d m=%0d tick=%0d got dt=%b oe=%b want dt=%b oe=%b",
                 slen_in, m, t, DT, DT_OE, exp_dt, exp_oe);
      end
      checks++;
      if (ISX !== is_ld) begin
        failures++;
        $display("FAIL isx_pulse tick=%0d got %b want %b", t, ISX, is_ld);
      end
      if (is_ld && ((t / per) < nwr)) do_write(wdat[t / per]);
    end
    checks++;
    if (TUF !== tuf_m) begin
      failures++;
      $display("FAIL frame_tuf got %b want %b", TUF, tuf_m);
    end
    checks++;
    if (TX !== tx_m) begin
      failures++;
      $display("FAIL frame_tx got %h want %h", TX, tx_m);
    end
    checks++;
    if (dut.tx_full !== full_m) begin
      failures++;
      $display("FAIL frame_txfull got %b want %b", dut.tx_full, full_m);
    end
  endtask

  task automatic test_reset();
    RST_ = 1'b1;
    #1 RST_ = 1'b0;
    #20;
    checks++;
    if ({TX, DT, DT_OE, TSreq, ISX, TUF} !== 21'd0) begin
      failures++;
      $display("FAIL reset_outputs got tx=%h dt=%b oe=%b tsreq=%b isx=%b tuf=%b want all 0",
               TX, DT, DT_OE, TSreq, ISX, TUF);
    end
    checks++;
    if (3'(dut.state) !== 3'b001) begin
      failures++;
      $display("FAIL reset_state got %b want 001", 3'(dut.state));
    end
    RST_ = 1'b1;
    tx_m = 16'h0; full_m = 1'b0; tuf_m = 1'b0;
    cyc();
  endtask

  task automatic test_single_word();
    do_write(16'h00A5);
    checks++;
    if (dut.tx_full !== 1'b1) begin
      failures++;
      $display("FAIL single_full_before got %b want 1", dut.tx_full);
    end
    frame(7, 0, 0, 1'b0);
  endtask

  task automatic test_multichannel();
    do_write(16'h003C);
    wdat[0] = 16'h00C3;
    frame(7, 1, 1, 1'b0);
    checks++;
    if (3'(dut.state) !== 3'b001) begin
      failures++;
      $display("FAIL multi_state_end got %b want 001", 3'(dut.state));
    end
  endtask

  task automatic test_underflow();
    do_write(16'h1234);
    frame(15, 0, 0, 1'b0);
    frame(15, 0, 0, 1'b0);
    checks++;
    if (TUF !== 1'b1) begin
      failures++;
      $display("FAIL underflow_set got %b want 1", TUF);
    end
    do_write(16'h5555);
    checks++;
    if (TUF !== 1'b0) begin
      failures++;
      $display("FAIL underflow_clear got %b want 0", TUF);
    end
  endtask

  task automatic test_autobuffer();
    TBUF = 1'b1; Twrap = 1'b0;
    do_write(16'hA5A5);
    SLEN = 5'd1; MWORD = 16'h0001;
    SCLK_en = 1'b1; TFSsm = 1'b1;
    cyc();
    SCLK_en = 1'b0; TFSsm = 1'b0;
    full_m = 1'b0;
    checks++;
    if ({TSreq, ISX} !== 2'b10) begin
      failures++;
      $display("FAIL ab_first_load got tsreq=%b isx=%b want 1 0", TSreq, ISX);
    end
    repeat (3) cyc();
    checks++;
    if (TSreq !== 1'b1) begin
      failures++;
      $display("FAIL ab_hold got %b want 1", TSreq);
    end
    SCLK_en = 1'b1;
    cyc();
    cyc();
    TSack = 1'b1;
    cyc();
    SCLK_en = 1'b0; TSack = 1'b0;
    tuf_m = 1'b1;
    checks++;
    if ({TSreq, ISX, DT_OE} !== 3'b001) begin
      failures++;
      $display("FAIL ab_ack_vs_load got tsreq=%b isx=%b oe=%b want 0 0 1", TSreq, ISX, DT_OE);
    end
    SCLK_en = 1'b1;
    cyc();
    cyc();
    SCLK_en = 1'b0;
    checks++;
    if (DT_OE !== 1'b0) begin
      failures++;
      $display("FAIL ab_frame_end got oe=%b want 0", DT_OE);
    end
    do_write(16'h0F0F);
    checks++;
    if (TSreq !== 1'b0) begin
      failures++;
      $display("FAIL ab_wr_no_req got %b want 0", TSreq);
    end
    Twrap = 1'b1;
    #1;
    checks++;
    if (ISX !== 1'b1) begin
      failures++;
      $display("FAIL ab_twrap got %b want 1", ISX);
    end
    Twrap = 1'b0; TBUF = 1'b0;
    cyc();
  endtask

  task automatic test_sp_en();
    logic [15:0] w;
    w = 16'hF00D;
    do_write(w);
    SLEN = 5'd15; MWORD = 16'h0000;
    SCLK_en = 1'b1; TFSsm = 1'b1;
    cyc();
    TFSsm = 1'b0;
    repeat (3) cyc();
    SCLK_en = 1'b0;
    full_m = 1'b0;
    checks++;
    if ({DT, DT_OE} !== {w[12], 1'b1}) begin
      failures++;
      $display("FAIL spen_mid got dt=%b oe=%b want dt=%b oe=1", DT, DT_OE, w[12]);
    end
    SP_EN = 1'b0;
    cyc();
    checks++;
    if ({DT, DT_OE, 3'(dut.state)} !== 5'b00001) begin
      failures++;
      $display("FAIL spen_clear got dt=%b oe=%b state=%b want 0 0 001", DT, DT_OE, 3'(dut.state));
    end
    SCLK_en = 1'b1; TFSsm = 1'b1;
    cyc();
    SCLK_en = 1'b0; TFSsm = 1'b0;
    checks++;
    if ({DT_OE, dut.tx_full, TX} !== {1'b0, full_m, tx_m}) begin
      failures++;
      $display("FAIL spen_hold got oe=%b full=%b tx=%h want 0 %b %h", DT_OE, dut.tx_full, TX, full_m, tx_m);
    end
    SP_EN = 1'b1;
    do_write(16'($urandom));
    frame(15, 0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    TBUF = 1'b1;
    do_write(16'h8001);
    SLEN = 5'd15; MWORD = 16'h0000;
    SCLK_en = 1'b1; TFSsm = 1'b1;
    cyc();
    TFSsm = 1'b0;
    cyc();
    cyc();
    SCLK_en = 1'b0; TBUF = 1'b0;
    checks++;
    if ({TSreq, DT_OE} !== 2'b11) begin
      failures++;
      $display("FAIL areset_pre got tsreq=%b oe=%b want 1 1", TSreq, DT_OE);
    end
    #1 RST_ = 1'b0;
    #1;
    checks++;
    if ({TX, DT, DT_OE, TSreq, ISX, TUF, dut.tx_full} !== 22'd0) begin
      failures++;
      $display("FAIL areset_async got tx=%h dt=%b oe=%b tsreq=%b isx=%b tuf=%b want all 0",
               TX, DT, DT_OE, TSreq, ISX, TUF);
    end
    RST_ = 1'b1;
    tx_m = 16'h0; full_m = 1'b0; tuf_m = 1'b0;
    cyc();
    do_write(16'hBEEF);
    w0dat = 16'h1111;
    frame(15, 0, 0, 1'b1);
    checks++;
    if ({TX, dut.tx_full, TUF} !== {16'h1111, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL b2b_result got tx=%h full=%b tuf=%b want 1111 1 0", TX, dut.tx_full, TUF);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      int sl, m, nwr;
      bit w0;
      sl  = $urandom_range(0, 20);
      m   = $urandom_range(0, 3);
      nwr = $urandom_range(0, m);
      w0  = 1'($urandom);
      for (int k = 0; k < 4; k++) wdat[k] = 16'($urandom);
      w0dat = 16'($urandom);
      if ($urandom_range(0, 3) != 0) do_write(16'($urandom));
      // Incomplete decode must not write.
      DMD = 16'($urandom); MTTX_E = 1'b1; EX_en = 1'b1; GO_Cx = 1'b0;
      cyc();
      MTTX_E = 1'b0; EX_en = 1'b0;
      frame(sl, m, nwr, w0);
    end
  endtask

  initial begin
    SP_EN = 1'b1; SCLK_en = 1'b0; TFSsm = 1'b0; SLEN = 5'd0; MWORD = 16'h0;
    DMD = 16'h0; MTTX_E = 1'b0; EX_en = 1'b0; GO_Cx = 1'b0;
    TBUF = 1'b0; TSack = 1'b0; Twrap = 1'b0;
    tx_m = 16'h0; full_m = 1'b0; tuf_m = 1'b0; w0dat = 16'h0;
    test_reset();
    test_single_word();
    test_multichannel();
    test_underflow();
    test_autobuffer();
    test_sp_en();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sport1_tx_ctl.md
Name: sport1_tx_ctl

Overview:
Transmit-side control for SPORT1, the mirror of the SPORT1 receive controller.
- Holds the TX data register, written by the core (DMD bus) or by autobuffer.
- On frame sync, loads a 16-bit shifter and serialises MSB-first onto DT, SLEN+1 bits per word.
- Multichannel: sends MWORD[7:0]+1 words per frame, with a one-bit gap between words.
- Raises the autobuffer request TSreq and the transmit interrupt ISX.
- Single-clock design: serial bit timing comes from the SCLK_en tick qualifier.

Parameters:
DW, 16, data/shifter width
CW, 5, bit-counter width (holds SLEN)

Ports:
DSPCLK  in  1  core clock; all state changes on posedge
RST_  in  1  asynchronous active-low reset
SP_EN  in  1  port enable; low = synchronous clear of the TX engine
SCLK_en  in  1  one-DSPCLK pulse per serial bit time; qualifies all serial activity
TFSsm  in  1  frame-sync-start, sampled on SCLK_en ticks
SLEN  in  5  word length minus 1 (0..15; values >15 treated as 15)
MWORD  in  16  multichannel config; [7:0] = words per frame minus 1
DMD  in  16  core data bus
MTTX_E  in  1  TX register write decode
EX_en  in  1  execute enable
GO_Cx  in  1  core cycle go
TBUF  in  1  autobuffer mode
TSack  in  1  autobuffer acknowledge
Twrap  in  1  autobuffer wrap indication
TX  out  16  transmit holding register
DT  out  1  serial data out
DT_OE  out  1  DT drive enable
TSreq  out  1  autobuffer request
ISX  out  1  transmit interrupt
TUF  out  1  sticky underflow flag

Behaviour:
Reset (RST_ low, async), all values cleared:
- TX=0, TXSHT=0, Bcnt=0, Wcnt=0, TX_full=0, TUF=0, TSreq=0, ISXa=0, DT=0, DT_OE=0.
- State = TX_idle.
- ISX follows TBUF ? Twrap : 0.

SP_EN low (synchronous): state->TX_idle, Bcnt=Wcnt=0, DT=0, DT_OE=0, ISXa=0. TX, TX_full, TUF and TSreq are held.

TX write:
- Write condition wr = MTTX_E & EX_en & GO_Cx.
- On wr: TX<=DMD, TX_full<=1, TUF<=0. The write is not gated by SCLK_en.

State machine, one-hot (TX_idle=3'b001, TX_shift=3'b010, TX_wstart=3'b100). Transitions occur only on DSPCLK edges with SCLK_en=1.
- TX_idle & TFSsm -> TX_shift (load). Wcnt<=MWORD[7:0].
- TX_idle & !TFSsm -> stay in TX_idle.
- TX_shift & Bcnt!=0: Bcnt<=Bcnt-1, DT<=TXSHT[Bcnt-1].
- TX_shift & Bcnt==0 & Wcnt==0 -> TX_idle. DT<=0, DT_OE<=0.
- TX_shift & Bcnt==0 & Wcnt!=0 -> TX_wstart. DT<=0, DT_OE stays 1, Wcnt<=Wcnt-1.
- TX_wstart -> TX_shift (load).

Load event (ld):
- Actions: TXSHT<=TX, Bcnt<=SLEN, DT<=TX[SLEN], DT_OE<=1, TX_full<=0.
- If TX_full=0 at load: the stale TX is resent and TUF<=1.
- wr and ld in the same cycle: the shifter takes the old TX, TX_full ends 1, TUF is not set by this load.

Timing:
- First DT bit appears the DSPCLK after the TFSsm tick.
- Word duration is SLEN+1 ticks.
- Frame duration is (MWORD[7:0]+1)*(SLEN+2)-1 ticks.

Autobuffer request:
- TSreq set on (ld & SP_EN & TBUF). Cleared on TSack.
- TSack has priority if set and clear coincide.
- wr does not set TSreq.

Interrupt:
- ISXa <= SP_EN & ld; a one-DSPCLK pulse.
- ISX = TBUF ? Twrap : ISXa.

Width rules:
- Bcnt and Wcnt decrement with no wrap (guarded by the ==0 checks).
- SLEN is clamped to 4'hF before loading Bcnt.

Decomposition:
- Shared include: state encodings TX_idle/TX_shift/TX_wstart alongside the RX encodings, plus the `da/`db delay macros.
- One sub-module, sport1_tx_shreg: TXSHT, Bcnt, DT mux/register and SLEN clamp. Inputs ld, shift_en, SLEN, TX. Outputs DT, Bcnteq0.
- The FSM, Wcnt, TX register, TSreq and ISX stay in the top level.

Test Plan:
- SLEN=7, MWORD=0, write TX=0x00A5, pulse TFSsm on a tick -> DT over 8 ticks = 1,0,1,0,0,1,0,1; DT_OE high exactly 8 ticks; ISX one-DSPCLK pulse at load; TX_full 1->0; TUF=0.
- SLEN=7, MWORD[7:0]=1, write 0x3C, TFSsm, write 0xC3 before word 1 ends -> DT = 00111100,0,11000011; DT_OE high 17 ticks; state returns to TX_idle.
- No write before TFSsm (TX=0x1234, TX_full=0), SLEN=15 -> 0x1234 resent MSB-first; TUF=1; next wr clears TUF.
- TBUF=1, Twrap=0: load -> TSreq=1 held until TSack; TSack coincident with a second load -> TSreq=0; ISX=0. Set Twrap=1 -> ISX=1.
- SP_EN dropped after 3 bits of an SLEN=15 word -> next cycle state TX_idle, DT=0, DT_OE=0; re-enable + TFSsm -> full fresh word.
- RST_ asserted mid-shift (async, no clock edge) -> all outputs to reset values immediately; wr and ld in the same cycle after reset -> old TX shifted, TX_full=1.
